seq_stuff_tx: RTL and testbench



---
 rtl/seq_pkg.sv | 24 ++
 rtl/seq_stuff_tx_if.sv | 12 +
 rtl/seq_stuff_tx.sv | 151 +++++++++++++++
 tb/tb_seq_stuff_tx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the bit-stuffed serial transmitter: state encoding,
// protocol defaults and counter sizing.
package seq_pkg;

  localparam int         DATA_W_DEF    = 8;
  localparam int         RUN_LEN_DEF   = 5;
  localparam int         ABORT_LEN_DEF = 7;
  localparam logic [7:0] FLAG_DEF      = 8'h7E;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN  = 3'd1,
    DATA  = 3'd2,
    STUFF = 3'd3,
    CLOSE = 3'd4,
    ABORT = 3'd5
  } state_t;

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/seq_stuff_tx_if.sv
// Parallel byte handshake into the transmitter.
interface seq_stuff_tx_if #(parameter int DATA_W = 8);

  logic [DATA_W-1:0] din;
  logic              din_last;
  logic              din_valid;
  logic              din_ready;

  modport master (output din, din_last, din_valid, input din_ready);
  modport slave  (input din, din_last, din_valid, output din_ready);

endinterface

// File: rtl/seq_stuff_tx.sv
// Bit-stuffed serial transmitter: flag, LSB-first data with a 0 inserted after
// every RUN_LEN consecutive data 1s, closing flag or abort run of 1s.
//
// state | meaning
// IDLE  | line idle (1), waiting for the first byte of a frame
// OPEN  | sending the opening flag, bit_cnt = flag bit index
// DATA  | sending shreg[0], bit_cnt = data bit index within the byte
// STUFF | sending an inserted 0; bit_cnt == DATA_W means the last byte is done
// CLOSE | sending the closing flag
// ABORT | sending ABORT_LEN 1s after an underrun
module seq_stuff_tx
  import seq_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                RUN_LEN   = RUN_LEN_DEF,
  parameter logic [DATA_W-1:0] FLAG      = DATA_W'(FLAG_DEF),
  parameter int                ABORT_LEN = ABORT_LEN_DEF
) (
  input  logic          clk,
  input  logic          rst,
  seq_stuff_tx_if.slave bus,
  output logic          j_out,
  output logic          j_valid,
  output logic          stuffed,
  output logic          aborted
);

  localparam int BW = cnt_w((DATA_W > ABORT_LEN) ? DATA_W : ABORT_LEN);
  localparam int OW = cnt_w(RUN_LEN);
  localparam int IW = (DATA_W < 2) ? 1 : $clog2(DATA_W);

  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] EXHAUSTED = BW'(DATA_W);
  localparam logic [BW-1:0] ABORT_END = BW'(ABORT_LEN - 1);
  localparam logic [OW-1:0] RUN_HIT   = OW'(RUN_LEN);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bit_cnt;
  logic [OW-1:0]     ones_cnt;
  logic              last_q;

  logic              cur_bit;
  logic [OW-1:0]     ones_nxt;
  logic              hit;
  logic              byte_end;
  logic              accept;

  assign cur_bit  = shreg[0];
  assign ones_nxt = cur_bit ? ones_cnt + 1'b1 : '0;
  assign hit      = cur_bit && (ones_nxt == RUN_HIT);
  assign byte_end = (bit_cnt == LAST_BIT);

  assign bus.din_ready = (state == IDLE) || (state == DATA && byte_end && !last_q);
  assign accept        = bus.din_valid && bus.din_ready;

  always_comb begin
    j_out = 1'b1;
    case (state)
      OPEN, CLOSE: j_out = FLAG[bit_cnt[IW-1:0]];
      DATA:        j_out = cur_bit;
      STUFF:       j_out = 1'b0;
      default:     j_out = 1'b1;
    endcase
  end

  assign j_valid = (state != IDLE);
  assign stuffed = (state == STUFF);
  assign aborted = (state == ABORT) && (bit_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      ones_cnt <= '0;
      last_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= bus.din;
            last_q  <= bus.din_last;
            bit_cnt <= '0;
            state   <= OPEN;
          end
        end
        OPEN: begin
          if (byte_end) begin
            bit_cnt  <= '0;
            ones_cnt <= '0;
            state    <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          ones_cnt <= ones_nxt;
          shreg    <= shreg >> 1;
          bit_cnt  <= bit_cnt + 1'b1;
          if (!byte_end) begin
            state <= hit ? STUFF : DATA;
          end else if (last_q) begin
            // A stuff owed by the final bit leaves bit_cnt at EXHAUSTED.
            if (hit) begin
              state <= STUFF;
            end else begin
              bit_cnt <= '0;
              state   <= CLOSE;
            end
          end else if (accept) begin
            shreg   <= bus.din;
            last_q  <= bus.din_last;
            bit_cnt <= '0;
            state   <= hit ? STUFF : DATA;
          end else begin
            bit_cnt <= '0;
            state   <= ABORT;
          end
        end
        STUFF: begin
          ones_cnt <= '0;
          if (bit_cnt == EXHAUSTED) begin
            bit_cnt <= '0;
            state   <= CLOSE;
          end else begin
            state <= DATA;
          end
        end
        CLOSE: begin
          if (byte_end) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ABORT: begin
          if (bit_cnt == ABORT_END) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_stuff_tx.sv
// Bench for seq_stuff_tx: table of directed frames, mid-frame reset, and random
// frames compared cycle by cycle against a line-level model of the protocol.
module tb_seq_stuff_tx;

  localparam int         RL = 5;
  localparam int         AL = 7;
  localparam logic [7:0] FL = 8'h7E;

  logic clk = 1'b0;
  logic rst;
  logic j_out, j_valid, stuffed, aborted;

  seq_stuff_tx_if #(.DATA_W(8)) bus ();

  seq_stuff_tx dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .j_out   (j_out),
    .j_valid (j_valid),
    .stuffed (stuffed),
    .aborted (aborted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One expected line cycle: bit, stuffed, aborted, din_ready.
  typedef struct packed {
    logic j;
    logic s;
    logic a;
    logic r;
  } exp_t;

  exp_t q[$];

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    int         n;
    bit         ab;
    int         exp_len;
    int         exp_st;
  } vec_t;

  vec_t tbl[8];

  task automatic set_vec(input int i, input logic [7:0] b0, input logic [7:0] b1,
                         input int n, input bit ab, input int len, input int st);
    tbl[i].b0 = b0; tbl[i].b1 = b1; tbl[i].n = n; tbl[i].ab = ab;
    tbl[i].exp_len = len; tbl[i].exp_st = st;
  endtask

  // Line model: flag, data bits with a 0 after each run of RL ones, then flag or abort.
  task automatic build(input logic [7:0] b[4], input int n, input bit ab);
    logic [7:0] fl;
    logic [7:0] cur;
    exp_t e;
    int run;
    bit lastb;
    fl  = FL;
    run = 0;
    q.delete();
    for (int k = 0; k < 8; k++) begin
      e = '{j: fl[k], s: 1'b0, a: 1'b0, r: 1'b0};
      q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      cur   = b[i];
      lastb = (i == n - 1);
      for (int k = 0; k < 8; k++) begin
        e = '{j: cur[k], s: 1'b0, a: 1'b0, r: (k == 7) && (!lastb || ab)};
        q.push_back(e);
        run = cur[k] ? run + 1 : 0;
        if (run == RL && !(ab && lastb && k == 7)) begin
          e = '{j: 1'b0, s: 1'b1, a: 1'b0, r: 1'b0};
          q.push_back(e);
          run = 0;
        end
      end
    end
    if (ab) begin
      for (int k = 0; k < AL; k++) begin
        e = '{j: 1'b1, s: 1'b0, a: (k == 0), r: 1'b0};
        q.push_back(e);
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        e = '{j: fl[k], s: 1'b0, a: 1'b0, r: 1'b0};
        q.push_back(e);
      end
    end
  endtask

  task automatic drive(input logic [7:0] b[4], input int n, input bit ab, input int idx);
    bus.din_valid = (idx < n);
    bus.din       = (idx < n) ? b[idx] : 8'h00;
    bus.din_last  = (idx == n - 1) && !ab;
  endtask

  // Called at a negedge with the DUT idle; returns at the first idle negedge after the frame.
  task automatic run_frame(input logic [7:0] b[4], input int n, input bit ab,
                           output int len, output int nst);
    int   idx;
    logic acc;
    build(b, n, ab);
    len = 0;
    nst = 0;
    idx = 0;
    drive(b, n, ab, idx);
    acc = bus.din_valid && bus.din_ready;
    @(posedge clk);
    if (acc) idx++;
    @(negedge clk);
    for (int p = 0; p < q.size(); p++) begin
      check($sformatf("line cyc %0d {jv,j,st,ab,rdy}", p),
            {27'd0, j_valid, j_out, stuffed, aborted, bus.din_ready},
            {27'd0, 1'b1, q[p].j, q[p].s, q[p].a, q[p].r});
      len += int'(j_valid);
      nst += int'(stuffed);
      drive(b, n, ab, idx);
      acc = bus.din_valid && bus.din_ready;
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
    end
    check("idle after frame {jv,j,st,ab,rdy}",
          {27'd0, j_valid, j_out, stuffed, aborted, bus.din_ready}, 32'b01001);
    check("bytes consumed", idx, n);
  endtask

  logic [7:0] bb[4];
  int len, nst;

  initial begin
    rst           = 1'b1;
    bus.din       = 8'h00;
    bus.din_last  = 1'b0;
    bus.din_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset {jv,j,st,ab,rdy}", {27'd0, j_valid, j_out, stuffed, aborted, bus.din_ready}, 32'b01001);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset idle", {27'd0, j_valid, j_out, stuffed, aborted, bus.din_ready}, 32'b01001);

    set_vec(0, 8'h00, 8'h00, 1, 1'b0, 24, 0);
    set_vec(1, 8'hFF, 8'h00, 1, 1'b0, 25, 1);
    set_vec(2, 8'hF8, 8'h03, 2, 1'b0, 33, 1);
    set_vec(3, 8'h7E, 8'h00, 1, 1'b0, 25, 1);
    set_vec(4, 8'h55, 8'h00, 1, 1'b1, 23, 0);
    set_vec(5, 8'h1F, 8'h00, 1, 1'b0, 25, 1);
    set_vec(6, 8'hFF, 8'hFF, 2, 1'b0, 35, 3);
    set_vec(7, 8'h0F, 8'h00, 1, 1'b0, 24, 0);

    // Frames run back to back: each is offered in the first idle cycle.
    for (int i = 0; i < 8; i++) begin
      bb[0] = tbl[i].b0; bb[1] = tbl[i].b1; bb[2] = 8'h00; bb[3] = 8'h00;
      run_frame(bb, tbl[i].n, tbl[i].ab, len, nst);
      check($sformatf("vec%0d j_valid cycles", i), len, tbl[i].exp_len);
      check($sformatf("vec%0d stuff cycles", i), nst, tbl[i].exp_st);
    end

    // Reset during data bit 3 of 0xFF, then a 0x0F frame must not inherit the run.
    bus.din = 8'hFF; bus.din_last = 1'b1; bus.din_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.din_valid = 1'b0;
    repeat (11) @(negedge clk);
    check("pre-reset data bit3 {jv,j,st}", {29'd0, j_valid, j_out, stuffed}, 32'b110);
    rst = 1'b1;
    @(negedge clk);
    check("mid-frame reset {jv,j,rdy}", {29'd0, j_valid, j_out, bus.din_ready}, 32'b011);
    rst = 1'b0;
    bb[0] = 8'h0F; bb[1] = 8'h00; bb[2] = 8'h00; bb[3] = 8'h00;
    run_frame(bb, 1, 1'b0, len, nst);
    check("after reset len", len, 24);
    check("after reset stuffs", nst, 0);

    for (int f = 0; f < 40; f++) begin
      int  n;
      bit  ab;
      n  = $urandom_range(1, 4);
      ab = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < 4; i++)
        bb[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_frame(bb, n, ab, len, nst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
